md_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage of the 5-stage pipeline.
//  It raises a stall request to the hazard unit and holds F/D/E until its result is ready.
//  It obeys FlushE from the hazard unit as a kill.
//  The result is muxed into ALUResultE in the cycle that MdDoneE_o is high.

---
 rtl/md_unit.sv | 213 +++++++++++++++++++++
 tb/tb_md_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies with a radix-2 shift-add and divides with a restoring divider,
// one bit per cycle. Both work on operand magnitudes, and the sign is fixed
// up on the final cycle. Divide-by-zero and signed overflow finish in one cycle.
module md_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            ValidE_i,
   input  logic [2:0]      Funct3E_i,
   input  logic [XLEN-1:0] SrcAE_i,
   input  logic [XLEN-1:0] SrcBE_i,
   input  logic            FlushE_i,
   output logic            MdStallE_o,
   output logic            MdDoneE_o,
   output logic [XLEN-1:0] MdResultE_o
);

   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0]   ZERO_W   = {XLEN{1'b0}};
   localparam logic [XLEN-1:0]   ONES_W   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Two's-complement negate of a single word
   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      neg_w = ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negate of a double-width product
   function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
      neg_dw = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t              state_r;
   logic [CW-1:0]       count_r;
   logic [2:0]          f3_r;
   logic [XLEN-1:0]     opnd_r;      // multiplicand magnitude (MUL) or divisor magnitude (DIV)
   logic [2*XLEN-1:0]   acc_r;       // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
   logic                neg_q_r;     // product / quotient must be negated
   logic                neg_rem_r;   // remainder must be negated
   logic                done_r;
   logic [XLEN-1:0]     result_r;

   logic                sign_a_s, sign_b_s, a_neg_s, b_neg_s;
   logic [XLEN-1:0]     mag_a_s, mag_b_s;
   logic                div_zero_s, ovf_s, fast_s;
   logic [XLEN-1:0]     fast_res_s;
   logic [XLEN:0]       mul_sum_s;
   logic [2*XLEN-1:0]   mul_next_s, prod_s;
   logic [XLEN:0]       div_sh_s;
   logic                div_ge_s;
   logic [XLEN-1:0]     div_sub_s;
   logic [2*XLEN-1:0]   div_next_s;
   logic [XLEN-1:0]     mul_final_s, div_final_s;
   logic                stall_s;

   // Accept-time decode: operand signedness, magnitudes and the single-cycle special cases
   always_comb begin
      sign_a_s = 1'b0;
      sign_b_s = 1'b0;
      case (Funct3E_i)
         3'b001:  begin sign_a_s = 1'b1; sign_b_s = 1'b1; end   // MULH
         3'b010:  begin sign_a_s = 1'b1; sign_b_s = 1'b0; end   // MULHSU
         3'b100:  begin sign_a_s = 1'b1; sign_b_s = 1'b1; end   // DIV
         3'b110:  begin sign_a_s = 1'b1; sign_b_s = 1'b1; end   // REM
         default: begin sign_a_s = 1'b0; sign_b_s = 1'b0; end
      endcase
      a_neg_s    = sign_a_s & SrcAE_i[XLEN-1];
      b_neg_s    = sign_b_s & SrcBE_i[XLEN-1];
      mag_a_s    = a_neg_s ? neg_w(SrcAE_i) : SrcAE_i;
      mag_b_s    = b_neg_s ? neg_w(SrcBE_i) : SrcBE_i;
      div_zero_s = Funct3E_i[2] & (SrcBE_i == ZERO_W);
      ovf_s      = Funct3E_i[2] & ~Funct3E_i[0] & (SrcAE_i == MIN_NEG) & (SrcBE_i == ONES_W);
      fast_s     = div_zero_s | ovf_s;
      if (div_zero_s) begin
         fast_res_s = Funct3E_i[1] ? SrcAE_i : ONES_W;
      end else if (ovf_s) begin
         fast_res_s = Funct3E_i[1] ? ZERO_W : MIN_NEG;
      end else begin
         fast_res_s = ZERO_W;
      end
   end

   // One iteration of shift-add multiply and restoring divide, plus final sign fix-up
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_W});
      mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
      prod_s     = neg_q_r ? neg_dw(mul_next_s) : mul_next_s;
      if (f3_r[1:0] == 2'b00) begin
         mul_final_s = prod_s[XLEN-1:0];
      end else begin
         mul_final_s = prod_s[2*XLEN-1:XLEN];
      end

      div_sh_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      div_ge_s  = (div_sh_s >= {1'b0, opnd_r});
      div_sub_s = div_sh_s[XLEN-1:0] - opnd_r;
      if (div_ge_s) begin
         div_next_s = {div_sub_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
         div_next_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
      if (f3_r[1]) begin
         div_final_s = neg_rem_r ? neg_w(div_next_s[2*XLEN-1:XLEN]) : div_next_s[2*XLEN-1:XLEN];
      end else begin
         div_final_s = neg_q_r ? neg_w(div_next_s[XLEN-1:0]) : div_next_s[XLEN-1:0];
      end
   end

   // Control FSM with registered result and one-cycle done pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= S_IDLE;
         count_r   <= {CW{1'b0}};
         f3_r      <= 3'b000;
         opnd_r    <= ZERO_W;
         acc_r     <= {(2*XLEN){1'b0}};
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         done_r    <= 1'b0;
         result_r  <= ZERO_W;
      end else begin
         done_r <= 1'b0;
         if (FlushE_i) begin
            state_r <= S_IDLE;
            count_r <= {CW{1'b0}};
         end else begin
            case (state_r)
               S_IDLE: begin
                  if (ValidE_i) begin
                     f3_r      <= Funct3E_i;
                     count_r   <= {CW{1'b0}};
                     neg_q_r   <= a_neg_s ^ b_neg_s;
                     neg_rem_r <= a_neg_s;
                     if (Funct3E_i[2]) begin
                        opnd_r <= mag_b_s;
                        acc_r  <= {ZERO_W, mag_a_s};
                     end else begin
                        opnd_r <= mag_a_s;
                        acc_r  <= {ZERO_W, mag_b_s};
                     end
                     if (fast_s) begin
                        result_r <= fast_res_s;
                        done_r   <= 1'b1;
                        state_r  <= S_DONE;
                     end else if (Funct3E_i[2]) begin
                        state_r <= S_DIV;
                     end else begin
                        state_r <= S_MUL;
                     end
                  end else begin
                     state_r <= S_IDLE;
                  end
               end
               S_MUL: begin
                  acc_r   <= mul_next_s;
                  count_r <= count_r + CNT_ONE;
                  if (count_r == CNT_LAST) begin
                     result_r <= mul_final_s;
                     done_r   <= 1'b1;
                     state_r  <= S_DONE;
                  end else begin
                     state_r <= S_MUL;
                  end
               end
               S_DIV: begin
                  acc_r   <= div_next_s;
                  count_r <= count_r + CNT_ONE;
                  if (count_r == CNT_LAST) begin
                     result_r <= div_final_s;
                     done_r   <= 1'b1;
                     state_r  <= S_DONE;
                  end else begin
                     state_r <= S_DIV;
                  end
               end
               S_DONE: begin
                  // ValidE_i here still belongs to the finishing instruction
                  state_r <= S_IDLE;
               end
               default: begin
                  state_r <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Stall request: held while an op is being accepted or iterating, never under flush or reset
   always_comb begin
      stall_s = 1'b0;
      if (rst_ni && !FlushE_i) begin
         stall_s = ((state_r == S_IDLE) && ValidE_i) || (state_r == S_MUL) || (state_r == S_DIV);
      end else begin
         stall_s = 1'b0;
      end
   end

   assign MdStallE_o  = stall_s;
   assign MdDoneE_o   = done_r;
   assign MdResultE_o = result_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: result values, stall counts, flush and reset behaviour.
module tb_md_unit;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic [2:0]  funct3;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] last_res;

   md_unit #(.XLEN(32)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .ValidE_i    (valid),
      .Funct3E_i   (funct3),
      .SrcAE_i     (src_a),
      .SrcBE_i     (src_b),
      .FlushE_i    (flush),
      .MdStallE_o  (stall),
      .MdDoneE_o   (done),
      .MdResultE_o (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Issue one op at the current cycle (called #1 after a rising edge, unit idle).
   // Holds ValidE_i high through the stall and the DONE cycle, scrambling the source
   // operands after accept, then checks result, stall count and the single done pulse.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
      int   stalls;
      logic seen;
      stalls = 0;
      seen   = 1'b0;
      funct3 = f3;
      src_a  = a;
      src_b  = b;
      valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (stall) stalls++;
         @(posedge clk);
         #1;
         src_a = $urandom;
         src_b = $urandom;
      end
      check_val({tag, "_done"}, {31'd0, seen}, 32'd1);
      check_val({tag, "_res"}, result, exp_res);
      check_val({tag, "_stalls"}, stalls, exp_stalls);
      @(posedge clk);
      #1;
      valid = 1'b0;
      #1;
      check_val({tag, "_pulse"}, {31'd0, done}, 32'd0);
      check_val({tag, "_idle"}, {31'd0, stall}, 32'd0);
      last_res = exp_res;
   endtask

   initial begin
      int done_cnt;
      rst_n  = 1'b0;
      valid  = 1'b1;
      funct3 = 3'b000;
      src_a  = 32'd1;
      src_b  = 32'd1;
      flush  = 1'b0;
      #12;
      check_val("rst_result", result, 32'h0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_stall", {31'd0, stall}, 32'd0);
      valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
      run_op("mulhu_sm",  3'b011, 32'h12345678, 32'h10,       32'h00000001, 33);
      run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("div_negb",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      run_op("rem_negb",  3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
      run_op("divu",      3'b101, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu",      3'b111, 32'd100,      32'd7,        32'd2,        33);
      run_op("divu_z",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu_z",    3'b111, 32'd5,        32'd0,        32'd5,        1);
      run_op("div_z",     3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);
      run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

      // Flush a DIV at iteration 10
      funct3 = 3'b100;
      src_a  = 32'd1000;
      src_b  = 32'd3;
      valid  = 1'b1;
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      check_val("flush_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      valid = 1'b0;
      #1;
      check_val("flush_done", {31'd0, done}, 32'd0);
      check_val("flush_idle", {31'd0, stall}, 32'd0);
      check_val("flush_res", result, last_res);
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      check_val("flush_no_done", done_cnt, 32'd0);
      run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

      // Reset in the middle of a MUL
      funct3 = 3'b000;
      src_a  = 32'd5;
      src_b  = 32'd6;
      valid  = 1'b1;
      @(posedge clk);
      #1;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("midrst_res", result, 32'h0);
      check_val("midrst_done", {31'd0, done}, 32'd0);
      check_val("midrst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      valid = 1'b0;
      @(posedge clk);
      #1;
      check_val("postrst_done", {31'd0, done}, 32'd0);
      run_op("divu_after_rst", 3'b101, 32'd9, 32'd3, 32'd3, 33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
